// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
//
// Instruction fetch stage for the lab MIPS CPU. Owns the program counter,
// drives the instruction ROM address combinationally and captures the
// returned word into the instruction register (IR) for decode.
//
// Each rising edge performs exactly one action, highest priority first:
//   reset    : pc <= RESET_PC, IR side cleared.
//   redirect : taken branch on a valid IR. pc <= branch target and the word
//              fetched at the old pc is squashed (one-cycle bubble).
//   hold     : stall, everything keeps its value.
//   load     : IR <= ROM word at pc, pc <= pc + 4, inst_count++.
//
// Ports
//   clk            system clock, rising-edge active
//   rst            synchronous, active-high reset
//   stall          hold pc, IR and counter this cycle
//   branch_taken   instruction in IR is a taken branch
//   branch_offset  signed word offset (imm field) of that branch
//   rom_addr       byte address to the instruction ROM (= pc)
//   rom_inst       word returned by the ROM for rom_addr
//   ir             registered instruction
//   ir_pc          byte address ir was fetched from
//   ir_valid       ir holds a real, non-squashed instruction
//   inst_count     instructions loaded into IR since reset, wraps mod 2^16
// -----------------------------------------------------------------------------
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_offset,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_inst,
    output logic [31:0] ir,
    output logic [31:0] ir_pc,
    output logic        ir_valid,
    output logic [15:0] inst_count
);

    typedef enum logic [1:0] {
        ACT_RESET,
        ACT_REDIRECT,
        ACT_HOLD,
        ACT_LOAD
    } action_t;

    action_t     action;
    logic [31:0] pc;
    logic [31:0] branch_target;

    assign rom_addr = pc;

    // The branch is relative to the delay-free successor of the branch itself,
    // so the target is computed from ir_pc, not from the already-advanced pc.
    assign branch_target = ir_pc + 32'd4
                         + {{14{branch_offset[15]}}, branch_offset, 2'b00};

    // A branch_taken on a squashed/empty IR is meaningless and is ignored,
    // letting the cycle fall through to stall or normal fetch.
    always_comb begin
        // NOTE: a default assigned first in always_comb guarantees every path
        // drives action, so no latch can be inferred.
        action = ACT_LOAD;
        if (rst)
            action = ACT_RESET;
        else if (branch_taken && ir_valid)
            action = ACT_REDIRECT;
        else if (stall)
            action = ACT_HOLD;
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values of the others (pc and ir_pc swap cleanly).
    always_ff @(posedge clk) begin
        unique case (action)
            ACT_RESET: begin
                pc         <= RESET_PC;
                ir         <= '0;
                ir_pc      <= '0;
                ir_valid   <= 1'b0;
                inst_count <= '0;
            end
            ACT_REDIRECT: begin
                // ir_pc and inst_count keep their values: a squash is not a load.
                pc       <= branch_target;
                ir       <= '0;
                ir_valid <= 1'b0;
            end
            ACT_HOLD: begin
                // Everything holds.
            end
            ACT_LOAD: begin
                ir         <= rom_inst;
                ir_pc      <= pc;
                ir_valid   <= 1'b1;
                pc         <= pc + 32'd4;
                inst_count <= inst_count + 16'd1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage for the lab MIPS CPU. It drives the address input of the instruction ROM and registers the returned word into an instruction register (IR) for the decode stage. It owns the program counter, sequential PC+4 stepping, stall hold and taken-branch redirect with wrong-path squash. It is the reading end of the instruction-memory interface: the ROM decodes the address combinationally, and this block supplies the address and captures the data.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset. Word 0 is a NOP.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold PC, IR and counter this cycle.
- branch_taken  in  1  decode/execute resolved that the instruction in IR is a taken branch.
- branch_offset  in  16  signed word offset (imm field) of that branch.
- rom_addr  out  32  byte address to the instruction ROM. Combinational, equals pc.
- rom_inst  in  32  instruction word returned combinationally by the ROM for rom_addr.
- ir  out  32  registered instruction.
- ir_pc  out  32  byte address that ir was fetched from.
- ir_valid  out  1  ir holds a real, non-squashed instruction.
- inst_count  out  16  number of instructions loaded into IR since reset. Wraps modulo 2^16.

## Operation
- Internal register pc (32 b). rom_addr = pc at all times.
- Priority of actions each edge, highest first: rst, then redirect, then stall, then normal.
- **rst:**
  - pc <= RESET_PC.
  - ir, ir_pc, inst_count <= 0.
  - ir_valid <= 0.
- **redirect** (branch_taken && ir_valid):
  - target = ir_pc + 4 + {{14{branch_offset[15]}}, branch_offset, 2'b00}.
  - pc <= target.
  - ir <= 0, ir_valid <= 0. This squashes the word fetched at the old pc.
  - ir_pc and inst_count hold.
  - Redirect overrides stall.
- branch_taken while ir_valid=0 is ignored. The cycle proceeds as stall or normal.
- **stall** (no redirect): pc, ir, ir_pc, ir_valid and inst_count all hold.
- **normal:**
  - ir <= rom_inst, ir_pc <= pc, ir_valid <= 1.
  - pc <= pc + 4.
  - inst_count <= inst_count + 1.
- Arithmetic:
  - All PC math is 32-bit unsigned modulo 2^32. 0xFFFF_FFFC + 4 = 0x0000_0000.
  - pc[1:0] are always 0 given an aligned RESET_PC.
  - The block does not mask or alias addresses. ROM aliasing above 0x7C is the ROM's concern.
- inst_count counts only normal loads, not squashes. It wraps 0xFFFF -> 0x0000.

## Timing
- Fetch latency: 1 cycle. The word at address A appears on ir the edge after pc = A.
- First edge after rst deasserts: ir = word at RESET_PC, ir_valid = 1, pc = RESET_PC + 4.
- Taken-branch penalty: 1 bubble.
  - Edge N: branch seen in IR; ir_valid -> 0 and pc -> target.
  - Edge N+1: ir = word at target, ir_valid = 1.
- rst asserted mid-stream: takes effect at the next edge regardless of stall or branch_taken. No partial update.
- Stall asserted for k cycles: outputs are unchanged for exactly k edges. rom_addr stays constant throughout.

## Test plan
- **Reset / sequential fetch**, ROM model with word 1 = 0x3c011234, RESET_PC = 0:
  - After rst, all outputs are 0.
  - Edge 1: ir=0, ir_pc=0, ir_valid=1.
  - Edge 2: ir=0x3c011234, ir_pc=4, rom_addr=8, inst_count=2.
- **Stall 3 cycles** with ir_pc=0x10: ir, ir_pc, rom_addr=0x14 and inst_count are unchanged for 3 edges, then resume at 0x14.
- **Not-taken branch:** ir_pc=0x2C, branch_taken=0 -> next ir_pc=0x30, no bubble.
- **Taken backward branch:** ir_pc=0x30, branch_offset=0xFFFB, branch_taken=1:
  - Next edge: pc=0x20, ir=0, ir_valid=0, inst_count unchanged.
  - Following edge: ir_pc=0x20, ir_valid=1.
- **Simultaneous branch_taken and stall:** redirect wins and pc=target. Separately, branch_taken with ir_valid=0 leaves pc stepping by 4.
- **Wrap and reset:**
  - RESET_PC=0xFFFF_FFFC: after two normal edges, ir_pc=0 and pc=4.
  - Force inst_count 0xFFFF -> next load gives 0x0000.
  - Assert rst together with branch_taken -> pc=RESET_PC.
